// File: rtl/div_pkg.sv
// Shared types and constant helpers for the iterative divider.
package div_pkg;

    localparam int unsigned MaxWidth = 128;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StDivide,
        StFixup,
        StDone
    } div_state_t;

    // Callers slice the low w bits of the result.
    function automatic logic [MaxWidth-1:0] all_ones(input int unsigned w);
        logic [MaxWidth-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < w) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MaxWidth-1:0] signed_min(input int unsigned w);
        logic [MaxWidth-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i + 1 == w) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Start/complete/ack handshake and operand/result bundle for iter_divider.
interface iter_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic             ack;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             complete;
    logic             busy;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, signed_op, ack, A, B,
        input  Q, R, complete, busy, div_zero, overflow
    );

    modport slave (
        input  start, signed_op, ack, A, B,
        output Q, R, complete, busy, div_zero, overflow
    );
endinterface

// File: rtl/clz_count.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module clz_count #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CntW = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CntW-1:0]  count_o
);

    // Scanning upward, the last set bit seen is the most significant one.
    always_comb begin
        count_o = CntW'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (value_i[i]) count_o = CntW'(int'(WIDTH) - 1 - i);
        end
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: signed/unsigned, leading-zero early exit,
// defined divide-by-zero and signed-overflow results.
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          SIGNED_EN  = 1'b1,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    iter_divider_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [MaxWidth-1:0] OnesFull = all_ones(WIDTH);
    localparam logic [MaxWidth-1:0] MinFull  = signed_min(WIDTH);
    localparam logic [WIDTH-1:0] Ones = OnesFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MinV = MinFull[WIDTH-1:0];

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d, rem_q, rem_d, divs_q, divs_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             complete_q, complete_d, div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] abs_a, abs_b, shifted;
    logic [CntW-1:0]  lz, n_steps;
    logic [WIDTH:0]   partial, trial;
    logic             borrow;

    assign abs_a = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;

    if (EARLY_EXIT) begin : g_clz
        clz_count #(.WIDTH(WIDTH)) u_clz (
            .value_i (abs_a),
            .count_o (lz)
        );
    end else begin : g_no_clz
        assign lz = '0;
    end

    assign n_steps = CntW'(WIDTH) - lz;
    assign shifted = abs_a << lz;

    // A WIDTH+1-bit trial keeps the borrow in the MSB even when the shifted
    // partial remainder exceeds 2^WIDTH.
    assign partial = {rem_q, work_q[WIDTH-1]};
    assign trial   = partial - {1'b0, divs_q};
    assign borrow  = trial[WIDTH];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        work_d     = work_q;
        rem_d      = rem_q;
        divs_d     = divs_q;
        q_d        = q_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        sgn_d      = sgn_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        complete_d = complete_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d        = bus.A;
                    b_d        = bus.B;
                    sgn_d      = bus.signed_op & SIGNED_EN;
                    complete_d = 1'b0;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = StSetup;
                end else if (state_q == StDone && bus.ack) begin
                    complete_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            StSetup: begin
                neg_quo_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = sgn_q & a_q[WIDTH-1];
                divs_d    = abs_b;
                work_d    = shifted;
                rem_d     = '0;
                cnt_d     = n_steps;
                if (b_q == '0) begin
                    div_zero_d = 1'b1;
                    state_d    = StFixup;
                end else if (n_steps == '0) begin
                    state_d = StFixup;
                end else begin
                    state_d = StDivide;
                end
            end
            StDivide: begin
                // work_q shifts dividend bits out the top and quotient bits in the bottom.
                work_d = {work_q[WIDTH-2:0], ~borrow};
                rem_d  = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFixup;
            end
            StFixup: begin
                q_d = neg_quo_q ? -work_q : work_q;
                r_d = neg_rem_q ? -rem_q : rem_q;
                if (div_zero_q) begin
                    q_d = Ones;
                    r_d = a_q;
                end
                if (sgn_q && a_q == MinV && b_q == Ones) begin
                    overflow_d = 1'b1;
                    q_d        = MinV;
                    r_d        = '0;
                end
                complete_d = 1'b1;
                state_d    = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            rem_q      <= '0;
            divs_q     <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            sgn_q      <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            complete_q <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            work_q     <= work_d;
            rem_q      <= rem_d;
            divs_q     <= divs_d;
            q_q        <= q_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            sgn_q      <= sgn_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            complete_q <= complete_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.Q        = q_q;
    assign bus.R        = r_q;
    assign bus.complete = complete_q;
    assign bus.div_zero = div_zero_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q == StSetup) || (state_q == StDivide) || (state_q == StFixup);

endmodule
